alu_div: RTL
============

ALU_DIV -- requirements
Module: alu_div

Interface
REQ-001 Parameter WIDTH, default 8: operand and result width in bits.
REQ-002 Clk  input  1  rising-edge clock for all state.
REQ-003 Clear_n  input  1  asynchronous, active-low reset.
REQ-004 Start  input  1  request strobe; Dividend and Divisor are sampled on the same edge.
REQ-005 Dividend  input  WIDTH  unsigned numerator.
REQ-006 Divisor  input  WIDTH  unsigned denominator.
REQ-007 Quotient  output  WIDTH  registered unsigned quotient.
REQ-008 Remainder  output  WIDTH  registered unsigned remainder; present only when ALU_DIV_REM_EN is defined.
REQ-009 Busy  output  1  high while a division is in progress.
REQ-010 Done  output  1  single-cycle pulse marking valid results.
REQ-011 DivZero  output  1  high with Done when the division was by zero; held until the next accepted Start.

Function
REQ-012 The block SHALL be a three-state FSM with states IDLE, CALC and DONE.
REQ-013 Start SHALL be accepted only in IDLE or DONE; Start in CALC SHALL be ignored, with no effect on operands or outputs.
REQ-014 On acceptance the block SHALL latch both operands, clear DivZero, and enter CALC with the step counter set to WIDTH; if Divisor is 0 it SHALL enter DONE instead.
REQ-015 Each CALC cycle SHALL perform one restoring step: shift partial remainder left 1 with the next dividend MSB, subtract Divisor if the result is greater than or equal to Divisor, shift 1 or 0 into the quotient, and decrement the counter.
REQ-016 The partial remainder SHALL be WIDTH+1 bits wide internally so that no step overflows.
REQ-017 When the counter reaches 0, the FSM SHALL transfer results to Quotient/Remainder and enter DONE.
REQ-018 Latency: Start accepted at edge k gives Done=1 after edge k+WIDTH+1; for a zero divisor, Done=1 after edge k+1.
REQ-019 Divide by zero SHALL give Quotient = all ones, Remainder = Dividend, and DivZero = 1.
REQ-020 DONE SHALL last exactly one cycle, then return to IDLE unless Start is accepted in that cycle, in which case the FSM enters CALC (or DONE for a zero divisor) directly.
REQ-021 Busy SHALL equal (state == CALC); Done SHALL equal (state == DONE).
REQ-022 Quotient, Remainder and DivZero SHALL hold their last values from DONE until the next result transfer; they SHALL NOT show intermediate CALC values.

Reset
REQ-023 Clear_n low SHALL immediately force the FSM to IDLE and clear the counter, Quotient, Remainder, Busy, Done and DivZero, regardless of the current state.
REQ-024 A reset during CALC SHALL abort the division with no Done pulse; the first Start after release SHALL behave as from power-up.

Configuration
REQ-025 With macro ALU_DIV_REM_EN defined, the Remainder port and its output register SHALL exist.
REQ-026 Without ALU_DIV_REM_EN, the Remainder port SHALL be absent; Quotient, DivZero, Done and latency SHALL be unchanged.

Structure
REQ-027 Package alu_pkg SHALL hold the FSM state typedef (IDLE, CALC, DONE) and the default WIDTH constant, for sharing with the existing ALU.
REQ-028 One combinational sub-module, alu_div_step, SHALL implement a single restoring step (partial remainder and divisor in; next remainder and quotient bit out).
REQ-029 No other sub-modules SHALL be used; the FSM, counter and registers SHALL live in alu_div.

Verification
REQ-030 Dividend=200, Divisor=7, Start for 1 cycle -> Busy for 8 cycles, Done after edge k+9, Quotient=28, Remainder=4, DivZero=0.
REQ-031 Dividend=5, Divisor=0 -> Done after edge k+1, Quotient=255, Remainder=5, DivZero=1, Busy never high.
REQ-032 Boundary values 255/1 -> 255 R0; 3/10 -> 0 R3; 255/255 -> 1 R0; 0/9 -> 0 R0.
REQ-033 Start 100/3, then Start 50/5 pulsed 3 cycles later -> second request ignored, Quotient=33, Remainder=1.
REQ-034 Start held high through DONE with 90/9 queued -> back-to-back operation with no IDLE cycle; second Done after 9 more edges with Quotient=10, Remainder=0.
REQ-035 Clear_n pulsed low 4 cycles into CALC -> outputs 0 immediately, no Done pulse; next Start 200/7 -> Quotient=28.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU constants and divider FSM state type
package alu_pkg;

  localparam int ALU_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/alu_div_step.sv
// rtl/alu_div_step.sv - one combinational restoring-division step
// Shifts the next dividend bit into the partial remainder and conditionally subtracts the divisor.
module alu_div_step #(
  parameter int WIDTH = alu_pkg::ALU_WIDTH
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH:0]   rem_o,
  output logic             q_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] dvs_ext;

  always_comb begin
    shifted = {rem_i[WIDTH-1:0], bit_i};
    dvs_ext = {1'b0, divisor_i};
    if (shifted >= dvs_ext) begin
      rem_o = shifted - dvs_ext;
      q_o   = 1'b1;
    end else begin
      rem_o = shifted;
      q_o   = 1'b0;
    end
  end

endmodule

// File: rtl/alu_div.sv
// rtl/alu_div.sv - multi-cycle unsigned restoring divider (IDLE/CALC/DONE)
// Remainder port and register exist only when ALU_DIV_REM_EN is defined.
module alu_div
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             Clk,
  input  logic             Clear_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic [WIDTH-1:0] Quotient,
`ifdef ALU_DIV_REM_EN
  output logic [WIDTH-1:0] Remainder,
`endif
  output logic             Busy,
  output logic             Done,
  output logic             DivZero
);

  localparam int CW = $clog2(WIDTH + 1);

  div_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dq_q, dq_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH:0]   prem_q, prem_d;
  logic [WIDTH-1:0] quot_q, quot_d;
`ifdef ALU_DIV_REM_EN
  logic [WIDTH-1:0] rem_q, rem_d;
`endif
  logic             dz_q, dz_d;

  logic             accept;
  logic             last_step;
  logic [WIDTH:0]   step_rem;
  logic             step_q;

  assign accept    = Start && (state_q != CALC);
  assign last_step = (state_q == CALC) && (cnt_q == CW'(1));

  alu_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (prem_q),
    .bit_i     (dq_q[WIDTH-1]),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .q_o       (step_q)
  );

  always_ff @(posedge Clk or negedge Clear_n) begin
    if (!Clear_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (Start) state_d = (Divisor == '0) ? DONE : CALC;
      CALC:    if (cnt_q == CW'(1)) state_d = DONE;
      DONE:    state_d = Start ? ((Divisor == '0) ? DONE : CALC) : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    Busy = (state_q == CALC);
    Done = (state_q == DONE);
  end

  // dq_q shifts dividend bits out of the top while quotient bits enter at the bottom.
  always_comb begin
    cnt_d  = cnt_q;
    dq_d   = dq_q;
    dvs_d  = dvs_q;
    prem_d = prem_q;
    quot_d = quot_q;
`ifdef ALU_DIV_REM_EN
    rem_d  = rem_q;
`endif
    dz_d   = dz_q;
    if (accept) begin
      cnt_d  = CW'(WIDTH);
      dq_d   = Dividend;
      dvs_d  = Divisor;
      prem_d = '0;
      dz_d   = (Divisor == '0);
      if (Divisor == '0) begin
        quot_d = '1;
`ifdef ALU_DIV_REM_EN
        rem_d  = Dividend;
`endif
      end
    end else if (state_q == CALC) begin
      cnt_d  = cnt_q - CW'(1);
      prem_d = step_rem;
      dq_d   = {dq_q[WIDTH-2:0], step_q};
      if (last_step) begin
        quot_d = {dq_q[WIDTH-2:0], step_q};
`ifdef ALU_DIV_REM_EN
        rem_d  = step_rem[WIDTH-1:0];
`endif
      end
    end
  end

  always_ff @(posedge Clk or negedge Clear_n) begin
    if (!Clear_n) begin
      cnt_q  <= '0;
      dq_q   <= '0;
      dvs_q  <= '0;
      prem_q <= '0;
      quot_q <= '0;
`ifdef ALU_DIV_REM_EN
      rem_q  <= '0;
`endif
      dz_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      dq_q   <= dq_d;
      dvs_q  <= dvs_d;
      prem_q <= prem_d;
      quot_q <= quot_d;
`ifdef ALU_DIV_REM_EN
      rem_q  <= rem_d;
`endif
      dz_q   <= dz_d;
    end
  end

  assign Quotient  = quot_q;
`ifdef ALU_DIV_REM_EN
  assign Remainder = rem_q;
`endif
  assign DivZero   = dz_q;

endmodule
